tick_sample_avg: RTL and testbench

Periodic sample sequencer and averager that consumes the 50 ms ready tick from the interval timer. On each accepted tick it runs one request/acknowledge transaction with a sensor interface, including a timeout. It accumulates 2^K good samples and emits their mean with a one-cycle valid strobe. It sits between the interval timer and the control logic that reads averaged sensor values.

---
 rtl/tick_sample_avg.sv | 145 ++++++++++++++
 tb/tb_tick_sample_avg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sample_avg.sv
// tick_sample_avg: on each accepted interval tick, request one sample from the
// sensor interface (with an acknowledge timeout), accumulate 2^K good samples
// and publish their truncated mean with a one-cycle avg_valid strobe.
//
// Sensor handshake: smp_req is a level that rises the cycle after a tick is
// accepted and stays high until smp_ack is sampled high (smp_data is captured
// on that same edge) or until TO_CYCLES cycles have elapsed without an ack.
// Both cases drop smp_req on the following cycle.
module tick_sample_avg #(
  parameter int DW        = 12,
  parameter int K         = 3,
  parameter int TO_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  input  logic          smp_ack,
  input  logic [DW-1:0] smp_data,
  output logic          smp_req,
  output logic [DW-1:0] avg_out,
  output logic          avg_valid,
  output logic          timeout_err,
  output logic          overrun,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);
  localparam logic [K-1:0]  CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;
  logic [DW+K-1:0] acc;
  logic [K-1:0]    cnt;
  logic [TW-1:0]   tocnt;
  logic [DW-1:0]   data_q;
  logic [DW+K-1:0] sum;

  // Decoded events for the current cycle.
  logic to_fire;
  logic win_done;
  logic ovr;

  // Sum is formed at full accumulator width so a window of all-ones cannot wrap.
  assign sum       = acc + {{K{1'b0}}, data_q};
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic and per-cycle event decode.
  always_comb begin
    state_n  = state_q;
    to_fire  = 1'b0;
    win_done = 1'b0;
    ovr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && enable) state_n = WAIT;
      end
      WAIT: begin
        ovr = tick;
        if (smp_ack) begin
          // An ack on the final wait cycle still wins over the timeout.
          state_n = ACCUM;
        end else if (tocnt == TO_LAST) begin
          state_n = IDLE;
          to_fire = 1'b1;
        end
      end
      ACCUM: begin
        ovr      = tick;
        win_done = (cnt == CNT_LAST);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs: strobes, request level and busy follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_req     <= 1'b0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      smp_req     <= (state_n == WAIT);
      avg_valid   <= win_done;
      timeout_err <= to_fire;
      overrun     <= ovr;
      busy        <= (state_n != IDLE);
    end
  end

  // Datapath: timeout counter, sample capture, accumulation and averaging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      tocnt   <= '0;
      data_q  <= '0;
      avg_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tocnt <= '0;
          // A disable while idle abandons the partial window.
          if (!enable) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        WAIT: begin
          if (smp_ack)       data_q <= smp_data;
          else if (!to_fire) tocnt  <= tocnt + TW'(1);
        end
        ACCUM: begin
          if (win_done) begin
            avg_out <= sum[DW+K-1:K];
            acc     <= '0;
            cnt     <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt + K'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sample_avg.sv
// Directed bench for tick_sample_avg (DW=12, K=3, TO_CYCLES=8). The driver
// issues sensor transactions and pushes hand-computed expected averages,
// timeouts and overruns; a negedge monitor pops and compares on each strobe.
module tb_tick_sample_avg;

  localparam int DW = 12;
  localparam int K  = 3;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          enable;
  logic          smp_ack;
  logic [DW-1:0] smp_data;
  logic          smp_req;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          timeout_err;
  logic          overrun;
  logic          busy;
  logic [1:0]    state_dbg;

  logic [DW-1:0] exp_q[$];
  logic          to_q[$];
  logic          ovr_q[$];

  int checks;
  int errors;

  tick_sample_avg #(.DW(DW), .K(K), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .smp_ack(smp_ack), .smp_data(smp_data), .smp_req(smp_req),
    .avg_out(avg_out), .avg_valid(avg_valid), .timeout_err(timeout_err),
    .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sensor transaction. dly<0: never ack (expect timeout).
  // ovr_at>=0: raise a second tick during the wait at that iteration.
  // drop_en: deassert enable while waiting, restore when acking.
  task automatic sample(input logic [DW-1:0] d, input int dly,
                        input int ovr_at, input bit drop_en);
    int n;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("req_rise", int'(smp_req), 1);
    if (drop_en) enable = 1'b0;
    if (dly < 0) begin
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (!smp_req) break;
        n++;
        @(posedge clk);
        #1;
      end
      check("req_high_cycles", n, TO);
      check("busy_after_timeout", int'(busy), 0);
    end else begin
      for (int i = 0; i < dly; i++) begin
        tick = (i == ovr_at);
        @(posedge clk);
        #1;
        tick = 1'b0;
      end
      smp_ack  = 1'b1;
      smp_data = d;
      enable   = 1'b1;
      @(posedge clk);
      #1;
      smp_ack  = 1'b0;
      smp_data = '0;
      check("req_fall", int'(smp_req), 0);
      check("busy_accum", int'(busy), 1);
    end
    cycles(3);
  endtask

  task automatic window(input logic [DW-1:0] d, input logic [DW-1:0] exp_avg);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(exp_avg);
      sample(d, 3, -1, 1'b0);
    end
  endtask

  // Scoreboard monitor: compare every strobe against the expected queues.
  always @(negedge clk) begin
    if (reset) begin
      if (avg_valid) begin
        if (exp_q.size() == 0) begin
          check("avg_unexpected", int'(avg_out), -1);
        end else begin
          check("avg_out", int'(avg_out), int'(exp_q.pop_front()));
        end
      end
      if (timeout_err) begin
        check("timeout_expected", to_q.size(), 1);
        if (to_q.size() != 0) void'(to_q.pop_front());
      end
      if (overrun) begin
        check("overrun_expected", ovr_q.size(), 1);
        if (ovr_q.size() != 0) void'(ovr_q.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] seq[8];
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    tick     = 1'b0;
    enable   = 1'b1;
    smp_ack  = 1'b0;
    smp_data = '0;
    cycles(3);
    check("rst_req", int'(smp_req), 0);
    check("rst_avg", int'(avg_out), 0);
    check("rst_valid", int'(avg_valid), 0);
    check("rst_to", int'(timeout_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    #2 reset = 1'b1;
    cycles(2);

    // 1: samples 100..800 -> mean 450, held afterwards.
    for (int i = 0; i < 8; i++) seq[i] = DW'((i + 1) * 100);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(12'd450);
      sample(seq[i], 3, -1, 1'b0);
      cycles(12);
    end
    cycles(10);
    check("avg_held", int'(avg_out), 450);

    // 2: full-scale window, then truncation of 1/8.
    window(12'd4095, 12'd4095);
    sample(12'd1, 2, -1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_q.push_back(12'd0);
      sample(12'd0, 2, -1, 1'b0);
    end

    // 3: timeout in mid-window leaves acc/cnt intact; ack on last wait cycle.
    for (int i = 0; i < 3; i++) sample(12'd16, 1, -1, 1'b0);
    to_q.push_back(1'b1);
    sample(12'd0, -1, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) exp_q.push_back(12'd16);
      sample(12'd16, 1, -1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(12'd20);
      sample(12'd20, TO - 1, -1, 1'b0);
    end

    // 4: second tick two cycles into a slow transaction -> one overrun.
    ovr_q.push_back(1'b1);
    sample(12'd24, 6, 1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_q.push_back(12'd24);
      sample(12'd24, 2, -1, 1'b0);
    end

    // 5: disabled ticks are ignored; disable in idle clears the window.
    for (int i = 0; i < 5; i++) sample(12'd100, 2, -1, 1'b0);
    enable = 1'b0;
    cycles(2);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    check("no_req_disabled", int'(smp_req), 0);
    check("no_busy_disabled", int'(busy), 0);
    cycles(2);
    enable = 1'b1;
    cycles(2);
    window(12'd40, 12'd40);
    // Disable during the wait still completes and counts the sample.
    sample(12'd32, 3, -1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_q.push_back(12'd32);
      sample(12'd32, 3, -1, 1'b0);
    end

    // 6: async reset during WAIT drops smp_req without a clock edge.
    for (int i = 0; i < 3; i++) sample(12'd500, 2, -1, 1'b0);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(2);
    check("req_before_reset", int'(smp_req), 1);
    #2 reset = 1'b0;
    #1;
    check("req_async_reset", int'(smp_req), 0);
    check("busy_async_reset", int'(busy), 0);
    check("avg_async_reset", int'(avg_out), 0);
    cycles(2);
    #3 reset = 1'b1;
    cycles(2);
    window(12'd7, 12'd7);

    cycles(10);
    check("avg_queue_drained", exp_q.size(), 0);
    check("timeout_queue_drained", to_q.size(), 0);
    check("overrun_queue_drained", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
